lc3_cc_stack: RTL and testbench
===============================

// Module: lc3_cc_stack
// PURPOSE
//   Parametrised condition-code unit for the LC-3 datapath.
//   - Derives one-hot N/Z/P flags from a WIDTH-bit data bus.
//   - Evaluates the branch-enable bit BEN from IR[11:9].
//   - Keeps a DEPTH-entry hardware stack of saved NZP values.
//   - The control FSM pushes on interrupt entry and pops on RTI.
//   - Sticky overflow/underflow error flags are cleared by software.
// PARAMETERS
//   WIDTH  16  data bus width in bits (>=2); the MSB is the sign bit
//   DEPTH   4  number of NZP save-stack entries (>=1)
//   CW     $clog2(DEPTH+1)  width of stack_count (derived localparam)
// PORTS
//   clk          in   1      system clock, rising edge
//   rst          in   1      synchronous reset, active-high
//   ld_cc        in   1      load NZP from data_bus
//   data_bus     in   WIDTH  value whose sign and zero state set NZP
//   ld_ben       in   1      register BEN from ir[11:9] and current NZP
//   ir           in   16     instruction register; only [11:9] is used
//   cc_push      in   1      push current NZP onto the save stack
//   cc_pop       in   1      pop top of stack into NZP
//   err_clr      in   1      clear ovf_err and unf_err
//   nzp          out  3      {n,z,p}, always one-hot after reset
//   ben          out  1      registered branch enable
//   stack_count  out  CW     number of valid stack entries (0..DEPTH)
//   stack_empty  out  1      stack_count == 0 (combinational decode)
//   stack_full   out  1      stack_count == DEPTH (combinational decode)
//   ovf_err      out  1      sticky: push attempted while full
//   unf_err      out  1      sticky: pop attempted while empty
// BEHAVIOUR
//   Reset, synchronous, when rst=1 at a clk edge:
//   - nzp=3'b010, ben=0, stack_count=0, ovf_err=0, unf_err=0.
//   - Stack contents are don't-care.
//   - rst overrides every other input in the same cycle.
//   - Reset mid-operation discards all saved entries.
//   Flag derivation on ld_cc, registered with 1-cycle latency:
//   - data_bus==0 -> 3'b010.
//   - data_bus[WIDTH-1]=1 -> 3'b100.
//   - Otherwise -> 3'b001. Exactly one bit is ever set.
//   BEN on ld_ben, 1-cycle latency:
//   - ben <= |(ir[11:9] & nzp), using the NZP value held BEFORE this edge.
//   - ld_cc and ld_ben in the same cycle: BEN uses the old flags.
//   - ben holds its value when ld_ben=0.
//   Stack operations, all taking effect at the clk edge:
//   - push only, not full: mem[count] <= nzp; count+1.
//   - push only, full: no write, count unchanged; ovf_err <= 1.
//   - pop only, not empty: nzp <= mem[count-1]; count-1.
//   - pop only, empty: nzp and count unchanged; unf_err <= 1.
//   - push and pop together, not empty: exchange.
//     nzp <= mem[count-1]; mem[count-1] <= old nzp; count unchanged.
//   - push and pop together, empty: push only (count 0->1); no error.
//   NZP write priority: pop (incl. exchange) > ld_cc > hold.
//   - ld_cc is ignored in any cycle where a pop loads NZP.
//   - ld_cc still loads if the pop underflowed.
//   Error flags:
//   - Set has priority over err_clr in the same cycle.
//   - Otherwise err_clr=1 clears both flags.
//   No combinational path from any input to any output except
//   stack_empty and stack_full, which decode the registered count.
// TESTING
//   1. Reset, then ld_cc with bus=16'h0000, then 16'h8001, then 16'h0001:
//      nzp = 010, 100, 001 on successive cycles; never multi-hot.
//   2. nzp=001; ld_cc bus=16'h8000 together with ld_ben, ir[11:9]=001:
//      next cycle ben=1, nzp=100.
//      Then ld_ben with ir=100 -> ben=1; ir=011 -> ben=0.
//   3. DEPTH=4, five pushes with distinct NZP values between them:
//      count 1..4, full=1 after the 4th; ovf_err=1 after the 5th.
//      Four pops restore the values in LIFO order.
//      A 5th pop sets unf_err and leaves nzp unchanged.
//   4. count=2, top=100, nzp=001; push and pop together:
//      nzp=100, top=001, count stays 2.
//      Empty stack with push and pop together: count=1, no error flags.
//   5. pop with ld_cc (bus=0) together, stack top=001: nzp=001.
//      err_clr with an underflowing pop in the same cycle: unf_err stays 1.
//   6. Assert rst with count=3 and both error flags set:
//      next cycle all outputs equal their reset values.
//      Repeat with WIDTH=8, DEPTH=1: bus=8'h80 gives nzp=100, and full
//      asserts after a single push.

Source files
------------

// File: rtl/lc3_cc_stack.sv
// LC-3 condition-code unit: NZP flags, branch-enable, and a small LIFO of
// saved NZP values with sticky overflow/underflow error flags.
module lc3_cc_stack #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_cc,
  input  logic [WIDTH-1:0] data_bus,
  input  logic             ld_ben,
  input  logic [15:0]      ir,
  input  logic             cc_push,
  input  logic             cc_pop,
  input  logic             err_clr,
  output logic [2:0]       nzp,
  output logic             ben,
  output logic [CW-1:0]    stack_count,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             ovf_err,
  output logic             unf_err
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [2:0]    mem [DEPTH];
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] top_idx;
  logic [2:0]    bus_flags;
  logic          exch;
  logic          do_push;
  logic          do_pop;
  logic          ovf_set;
  logic          unf_set;
  logic          pop_load;

  assign stack_empty = (stack_count == '0);
  assign stack_full  = (stack_count == CW'(DEPTH));
  assign wr_idx      = IW'(stack_count);
  assign top_idx     = IW'(stack_count - CW'(1));

  // Sign/zero classification of the bus; exactly one bit set.
  always_comb begin
    bus_flags = 3'b001;
    if (data_bus == '0)
      bus_flags = 3'b010;
    else if (data_bus[WIDTH-1])
      bus_flags = 3'b100;
  end

  // Push+pop on an empty stack degrades to a plain push.
  always_comb begin
    exch     = cc_push & cc_pop & ~stack_empty;
    do_push  = cc_push & ~exch & ~stack_full;
    ovf_set  = cc_push & ~cc_pop & stack_full;
    do_pop   = cc_pop & ~cc_push & ~stack_empty;
    unf_set  = cc_pop & ~cc_push & stack_empty;
    pop_load = exch | do_pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nzp         <= 3'b010;
      ben         <= 1'b0;
      stack_count <= '0;
      ovf_err     <= 1'b0;
      unf_err     <= 1'b0;
    end else begin
      if (pop_load)
        nzp <= mem[top_idx];
      else if (ld_cc)
        nzp <= bus_flags;

      if (ld_ben)
        ben <= |(ir[11:9] & nzp);

      if (do_push)
        stack_count <= stack_count + CW'(1);
      else if (do_pop)
        stack_count <= stack_count - CW'(1);

      if (ovf_set)
        ovf_err <= 1'b1;
      else if (err_clr)
        ovf_err <= 1'b0;

      if (unf_set)
        unf_err <= 1'b1;
      else if (err_clr)
        unf_err <= 1'b0;
    end
  end

  // Storage needs no reset; only entries below stack_count are ever read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (do_push)
        mem[wr_idx] <= nzp;
      else if (exch)
        mem[top_idx] <= nzp;
    end
  end

endmodule

// File: tb/tb_lc3_cc_stack.sv
// Bench for lc3_cc_stack: two instances (16/4 and 8/1) driven from shared
// controls, checked each cycle against a stack model plus literal pins.
module tb_lc3_cc_stack;

  typedef struct packed {
    logic [2:0]      nzp;
    logic            ben;
    logic [3:0][2:0] stk;
    logic [2:0]      cnt;
    logic            ovf;
    logic            unf;
  } ms_t;

  logic        clk = 1'b0;
  logic        rst, ld_cc, ld_ben, cc_push, cc_pop, err_clr;
  logic [15:0] data_bus, ir;
  logic [7:0]  bus_b;

  logic [2:0] nzp_a, cnt_a;
  logic       ben_a, empty_a, full_a, ovf_a, unf_a;
  logic [2:0] nzp_b;
  logic       cnt_b, ben_b, empty_b, full_b, ovf_b, unf_b;

  ms_t ma, mb;
  int  n_chk = 0;
  int  n_fail = 0;

  assign bus_b = data_bus[7:0];

  always #5 clk = ~clk;

  lc3_cc_stack #(.WIDTH(16), .DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .ld_cc(ld_cc), .data_bus(data_bus), .ld_ben(ld_ben),
    .ir(ir), .cc_push(cc_push), .cc_pop(cc_pop), .err_clr(err_clr),
    .nzp(nzp_a), .ben(ben_a), .stack_count(cnt_a), .stack_empty(empty_a),
    .stack_full(full_a), .ovf_err(ovf_a), .unf_err(unf_a));

  lc3_cc_stack #(.WIDTH(8), .DEPTH(1)) dut_b (
    .clk(clk), .rst(rst), .ld_cc(ld_cc), .data_bus(bus_b), .ld_ben(ld_ben),
    .ir(ir), .cc_push(cc_push), .cc_pop(cc_pop), .err_clr(err_clr),
    .nzp(nzp_b), .ben(ben_b), .stack_count(cnt_b), .stack_empty(empty_b),
    .stack_full(full_b), .ovf_err(ovf_b), .unf_err(unf_b));

  // One clock of architectural behaviour, computed from the old state.
  function automatic ms_t mstep(input ms_t s, input int depth, input logic [2:0] fl);
    ms_t  r;
    logic ovs, uns;
    r = s;
    ovs = 1'b0;
    uns = 1'b0;
    if (rst) begin
      r.nzp = 3'b010; r.ben = 1'b0; r.cnt = 3'd0; r.ovf = 1'b0; r.unf = 1'b0;
      return r;
    end
    if (ld_ben) r.ben = |(ir[11:9] & s.nzp);
    if (cc_push && cc_pop && s.cnt != 3'd0) begin
      r.nzp = s.stk[s.cnt - 3'd1];
      r.stk[s.cnt - 3'd1] = s.nzp;
    end else if (cc_push) begin
      if (int'(s.cnt) < depth) begin
        r.stk[s.cnt] = s.nzp;
        r.cnt = s.cnt + 3'd1;
      end else ovs = 1'b1;
      if (ld_cc) r.nzp = fl;
    end else if (cc_pop) begin
      if (s.cnt != 3'd0) begin
        r.nzp = s.stk[s.cnt - 3'd1];
        r.cnt = s.cnt - 3'd1;
      end else begin
        uns = 1'b1;
        if (ld_cc) r.nzp = fl;
      end
    end else if (ld_cc) r.nzp = fl;
    r.ovf = ovs ? 1'b1 : (err_clr ? 1'b0 : s.ovf);
    r.unf = uns ? 1'b1 : (err_clr ? 1'b0 : s.unf);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("a_nzp", 32'(nzp_a), 32'(ma.nzp));
    chk("a_ben", 32'(ben_a), 32'(ma.ben));
    chk("a_cnt", 32'(cnt_a), 32'(ma.cnt));
    chk("a_empty", 32'(empty_a), 32'(ma.cnt == 3'd0));
    chk("a_full", 32'(full_a), 32'(ma.cnt == 3'd4));
    chk("a_ovf", 32'(ovf_a), 32'(ma.ovf));
    chk("a_unf", 32'(unf_a), 32'(ma.unf));
    chk("a_onehot", 32'($countones(nzp_a)), 32'd1);
    chk("b_nzp", 32'(nzp_b), 32'(mb.nzp));
    chk("b_ben", 32'(ben_b), 32'(mb.ben));
    chk("b_cnt", 32'(cnt_b), 32'(mb.cnt));
    chk("b_empty", 32'(empty_b), 32'(mb.cnt == 3'd0));
    chk("b_full", 32'(full_b), 32'(mb.cnt == 3'd1));
    chk("b_ovf", 32'(ovf_b), 32'(mb.ovf));
    chk("b_unf", 32'(unf_b), 32'(mb.unf));
  endtask

  task automatic tick();
    logic [2:0] fa, fb;
    @(posedge clk);
    fa = (data_bus == 16'h0) ? 3'b010 : ($signed(data_bus) < 0 ? 3'b100 : 3'b001);
    fb = (bus_b == 8'h0) ? 3'b010 : ($signed(bus_b) < 0 ? 3'b100 : 3'b001);
    ma = mstep(ma, 4, fa);
    mb = mstep(mb, 1, fb);
    @(negedge clk);
    check_all();
  endtask

  task automatic set(input logic p, input logic q, input logic l, input logic [15:0] b);
    rst = 1'b0; ld_ben = 1'b0; err_clr = 1'b0; ir = 16'h0;
    cc_push = p; cc_pop = q; ld_cc = l; data_bus = b;
  endtask

  logic [15:0] bv [4] = '{16'h0000, 16'h0001, 16'h8000, 16'h0000};
  logic [2:0]  pe [4] = '{3'b100, 3'b001, 3'b010, 3'b100};

  initial begin
    set(0, 0, 0, 16'h0);
    rst = 1'b1;
    tick();
    chk("rst_nzp", 32'(nzp_a), 32'(3'b010));
    chk("rst_cnt", 32'(cnt_a), 32'd0);

    // Flag derivation
    set(0, 0, 1, 16'h0000); tick(); chk("t1_zero", 32'(nzp_a), 32'(3'b010));
    set(0, 0, 1, 16'h8001); tick(); chk("t1_neg", 32'(nzp_a), 32'(3'b100));
    set(0, 0, 1, 16'h0001); tick(); chk("t1_pos", 32'(nzp_a), 32'(3'b001));

    // BEN uses pre-edge flags
    set(0, 0, 1, 16'h8000); ld_ben = 1'b1; ir = 16'h0200; tick();
    chk("t2_ben_old", 32'(ben_a), 32'd1);
    chk("t2_nzp", 32'(nzp_a), 32'(3'b100));
    set(0, 0, 0, 16'h0); ld_ben = 1'b1; ir = 16'h0800; tick();
    chk("t2_ben_n", 32'(ben_a), 32'd1);
    set(0, 0, 0, 16'h0); ld_ben = 1'b1; ir = 16'h0600; tick();
    chk("t2_ben_0", 32'(ben_a), 32'd0);

    // Fill, overflow, drain in LIFO order, underflow
    for (int i = 0; i < 5; i++) begin
      set(1, 0, 0, 16'h0); tick();
      chk("t3_cnt", 32'(cnt_a), (i < 3) ? 32'(i + 1) : 32'd4);
      if (i == 3) chk("t3_full", 32'(full_a), 32'd1);
      if (i == 4) chk("t3_ovf", 32'(ovf_a), 32'd1);
      if (i < 4) begin
        set(0, 0, 1, bv[i]); tick();
      end
    end
    for (int i = 0; i < 4; i++) begin
      set(0, 1, 0, 16'h0); tick();
      chk("t3_pop", 32'(nzp_a), 32'(pe[i]));
    end
    set(0, 1, 0, 16'h0); tick();
    chk("t3_unf", 32'(unf_a), 32'd1);
    chk("t3_hold", 32'(nzp_a), 32'(3'b100));

    set(0, 0, 0, 16'h0); err_clr = 1'b1; tick();
    chk("clr_ovf", 32'(ovf_a), 32'd0);
    chk("clr_unf", 32'(unf_a), 32'd0);

    // Exchange
    set(0, 0, 1, 16'h0000); tick();
    set(1, 0, 0, 16'h0);    tick();
    set(0, 0, 1, 16'h8000); tick();
    set(1, 0, 0, 16'h0);    tick();
    set(0, 0, 1, 16'h0001); tick();
    set(1, 1, 0, 16'h0); tick();
    chk("t4_xchg_nzp", 32'(nzp_a), 32'(3'b100));
    chk("t4_xchg_cnt", 32'(cnt_a), 32'd2);
    set(0, 1, 0, 16'h0); tick();
    chk("t4_top_old", 32'(nzp_a), 32'(3'b001));
    set(0, 1, 0, 16'h0); tick();
    chk("t4_cnt0", 32'(cnt_a), 32'd0);
    set(1, 1, 0, 16'h0); tick();
    chk("t4_empty_pp", 32'(cnt_a), 32'd1);
    chk("t4_no_ovf", 32'(ovf_a), 32'd0);
    chk("t4_no_unf", 32'(unf_a), 32'd0);

    // Pop beats ld_cc; set beats err_clr; ld_cc loads on underflow
    set(0, 1, 0, 16'h0);    tick();
    set(0, 0, 1, 16'h0001); tick();
    set(1, 0, 0, 16'h0);    tick();
    set(0, 0, 1, 16'h8000); tick();
    set(0, 1, 1, 16'h0000); tick();
    chk("t5_pop_prio", 32'(nzp_a), 32'(3'b001));
    set(0, 1, 0, 16'h0); err_clr = 1'b1; tick();
    chk("t5_set_prio", 32'(unf_a), 32'd1);
    set(0, 1, 1, 16'h8000); tick();
    chk("t5_unf_ldcc", 32'(nzp_a), 32'(3'b100));

    // Reset mid-operation
    for (int i = 0; i < 5; i++) begin
      set(1, 0, 0, 16'h0); tick();
    end
    set(0, 1, 0, 16'h0); ld_ben = 1'b1; ir = 16'h0E00; tick();
    chk("t6_cnt3", 32'(cnt_a), 32'd3);
    chk("t6_ovf", 32'(ovf_a), 32'd1);
    chk("t6_ben", 32'(ben_a), 32'd1);
    set(1, 1, 1, 16'h8000); rst = 1'b1; ld_ben = 1'b1; ir = 16'h0E00; tick();
    chk("t6_rst_nzp", 32'(nzp_a), 32'(3'b010));
    chk("t6_rst_ben", 32'(ben_a), 32'd0);
    chk("t6_rst_cnt", 32'(cnt_a), 32'd0);
    chk("t6_rst_err", 32'({ovf_a, unf_a}), 32'd0);

    // Narrow instance: sign bit at bit 7, single-entry stack
    set(0, 0, 1, 16'h0080); tick();
    chk("t6_b_neg", 32'(nzp_b), 32'(3'b100));
    chk("t6_a_pos", 32'(nzp_a), 32'(3'b001));
    set(1, 0, 0, 16'h0); tick();
    chk("t6_b_full", 32'(full_b), 32'd1);
    chk("t6_a_notfull", 32'(full_a), 32'd0);
    set(1, 0, 0, 16'h0); tick();
    chk("t6_b_ovf", 32'(ovf_b), 32'd1);
    set(0, 1, 0, 16'h0); tick();
    chk("t6_b_pop", 32'(nzp_b), 32'(3'b100));

    set(0, 0, 0, 16'h0); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
